// File: rtl/cmd_frame_arbiter.sv
// Round-robin arbiter that grants one command source at a time and serialises its
// payload as a framed packet (HDR, ID, LEN, payload MSB-first, XOR checksum).
module cmd_frame_arbiter #(
  parameter int          N_REQ    = 4,
  parameter int          MAX_LEN  = 4,
  parameter logic [7:0]  HDR_BYTE = 8'hCA
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*8*MAX_LEN-1:0] req_data,
  input  logic [N_REQ*3-1:0]         req_len,
  output logic [N_REQ-1:0]           grant,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);

  localparam int               PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int               DW        = 8 * MAX_LEN;
  localparam logic [PTR_W:0]   N_REQ_W   = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [3:0]       MAX_LEN_W = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ID,
    LEN,
    PAY,
    CSUM
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [DW-1:0]      data_q, data_d;
  logic [2:0]         len_q, len_d;
  logic [2:0]         id_q, id_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         drop_q, drop_d;

  // Per-source views of the flattened payload and length buses.
  logic [DW-1:0] data_arr [N_REQ];
  logic [2:0]    len_arr  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DW +: DW];
    assign len_arr[gi]  = req_len[gi*3 +: 3];
  end

  // Rotate requests so bit 0 is the source at ptr; the lowest set bit then wins.
  logic [N_REQ-1:0] req_rot;
  logic [PTR_W-1:0] win_off;
  logic             win_found;
  logic [PTR_W:0]   win_sum;
  logic [PTR_W-1:0] win_idx;

  assign req_rot = N_REQ'({req, req} >> ptr_q);

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        win_off   = PTR_W'(k);
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= N_REQ_W) begin
      win_idx = PTR_W'(win_sum - N_REQ_W);
    end else begin
      win_idx = win_sum[PTR_W-1:0];
    end
  end

  logic [DW-1:0] sel_data;
  logic [2:0]    sel_len;
  logic          sel_len_ok;

  assign sel_data   = data_arr[win_idx];
  assign sel_len    = len_arr[win_idx];
  assign sel_len_ok = (sel_len != 3'd0) && ({1'b0, sel_len} <= MAX_LEN_W);

  // Payload goes out most significant used byte first.
  logic [2:0] pay_idx;
  logic [7:0] pay_byte;

  assign pay_idx = len_q - 3'd1 - cnt_q;

  always_comb begin
    pay_byte = '0;
    for (int b = 0; b < MAX_LEN; b++) begin
      if (pay_idx == 3'(b)) begin
        pay_byte = data_q[b*8 +: 8];
      end
    end
  end

  logic [7:0] cur_byte;
  logic       accept;

  always_comb begin
    cur_byte = '0;
    case (state_q)
      HDR:     cur_byte = HDR_BYTE;
      ID:      cur_byte = {5'b0, id_q};
      LEN:     cur_byte = {5'b0, len_q};
      PAY:     cur_byte = pay_byte;
      CSUM:    cur_byte = csum_q;
      default: cur_byte = '0;
    endcase
  end

  assign out_valid = (state_q != IDLE);
  assign out_last  = (state_q == CSUM);
  assign busy      = (state_q != IDLE);
  assign out_data  = cur_byte;
  assign grant     = grant_q;
  assign drop_cnt  = drop_q;
  assign accept    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    data_d  = data_q;
    len_d   = len_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    drop_d  = drop_q;

    if (accept && (state_q != CSUM)) begin
      csum_d = csum_q ^ cur_byte;
    end

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          data_d  = sel_data;
          len_d   = sel_len;
          id_d    = 3'(win_idx);
          ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          if (sel_len_ok) begin
            state_d = HDR;
            csum_d  = '0;
            cnt_d   = '0;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      HDR:  if (accept) state_d = ID;
      ID:   if (accept) state_d = LEN;
      LEN: begin
        if (accept) begin
          state_d = PAY;
          cnt_d   = '0;
        end
      end
      PAY: begin
        if (accept) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d = CSUM;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      CSUM: if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      len_q   <= len_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: doc/cmd_frame_arbiter.md
Name: cmd_frame_arbiter

Overview:
- Shares the single Ethernet command byte channel between N_REQ command sources using a round-robin arbiter.
- Each source holds a level request plus a 1-4 byte payload.
- The block grants one source, latches its payload, and serialises a framed packet (header, ID, length, payload, XOR checksum) onto a valid/ready byte stream toward the UDP TX packer.
- It replaces ad hoc per-trigger command sequencing with fair, back-pressure-aware scheduling.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_LEN, 4, maximum payload bytes per frame. The req_data slice width is 8*MAX_LEN.
- HDR_BYTE, 8'hCA, first byte of every frame.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  level request per source; held until that source's grant pulse.
- req_data  in  N_REQ*8*MAX_LEN  payload per source; slice i = bits [i*8*MAX_LEN +: 8*MAX_LEN].
- req_len  in  N_REQ*3  payload length per source; slice i = bits [i*3 +: 3]. Valid range is 1..MAX_LEN.
- grant  out  N_REQ  one-hot, single-cycle pulse: request accepted and its data latched.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the byte when out_valid & out_ready.
- out_last  out  1  high with the checksum byte.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  8  count of rejected requests with invalid length; saturates at 255.

Behaviour:
- Reset: at the rising edge with rst=1, all outputs go to 0, state goes to IDLE, the round-robin pointer goes to 0, and the checksum goes to 0. This applies mid-frame too: the frame is abandoned with no out_last, and no grant is issued that cycle.
- States: IDLE, HDR, ID, LEN, PAY, CSUM.
- IDLE, no req: remain in IDLE.
- IDLE, any req:
  - Winner = first asserted req searching from index ptr upward, wrapping at N_REQ-1 to 0.
  - On the next edge: grant[winner]=1 for exactly one cycle; latch data, len and ID; set ptr = (winner+1) mod N_REQ.
  - If latched len is 0 or > MAX_LEN: drop_cnt++ (saturating), stay in IDLE, send no frame.
  - Otherwise: go to HDR with out_valid=1 in the same cycle as grant.
- Latency: req sampled at edge t gives grant and first out_valid at cycle t+1.
- Byte transfer and sequencing:
  - A byte advances only when out_valid & out_ready. While out_ready=0, out_data, out_valid and out_last hold stable.
  - out_valid stays high continuously from HDR through CSUM; there are no bubbles when out_ready is held high.
- Frame bytes:
  - HDR: HDR_BYTE.
  - ID: {5'b0, winner[2:0]}.
  - LEN: {5'b0, len}.
  - PAY: byte k (k=0..len-1) = data[8*(len-1-k) +: 8], most significant used byte first. A byte counter of 3 bits runs from 0 to len-1.
  - CSUM: XOR of every preceding byte of the frame, with out_last=1.
- Checksum: a running XOR register is cleared on entry to HDR and updated on each accepted byte.
- End of frame: when CSUM is accepted, return to IDLE with out_valid=0 next cycle. Arbitration restarts there, so there is a minimum one-cycle gap between frames.
- Fairness: while a frame is in flight, requests are not sampled; requesters keep req high. Each source that holds req continuously is served within N_REQ frames.
- Simultaneous events:
  - req deasserting during a non-granted source's frame means it is simply not selected.
  - A new req on the source just served is allowed but takes lowest priority.
- Widths: all arithmetic is unsigned; ptr is clog2(N_REQ) bits and wraps modulo N_REQ.

Test Plan:
- Single request: req[2]=1, data=32'h00001234, len=2, out_ready=1 -> grant=4'b0100 one cycle, then bytes CA 02 02 12 34 EC on consecutive cycles, out_last only on EC, busy low one cycle later.
- Round-robin: req=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0; ID bytes 00,01,02,03,00.
- Back-pressure: len=4 frame with out_ready toggled 1,0,0,1,... -> each byte held stable while out_ready=0; total 8 accepted bytes; checksum equals XOR of the first 7.
- Invalid length: req[1] with len=0, then len=5 -> two grant pulses, no out_valid, drop_cnt=2. Force 300 drops -> drop_cnt stays 255.
- Reset mid-frame: assert rst during PAY -> next cycle out_valid=0, busy=0, ptr=0. With req=4'b1010 afterwards, source 1 is granted first.
- Pointer wrap: N_REQ=4, serve source 3 only, then req=4'b1001 -> source 0 is granted next, then source 3.
